// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// The optional signed mode is enabled with SHIFT_ADD_MULTIPLIER_SIGNED_EN.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // The counter must hold DATA_WIDTH itself, not only DATA_WIDTH-1.
  function automatic int calc_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Accumulator, operand shift registers, iteration counter and optional sign fix-up.
// Signed operation is built only when SHIFT_ADD_MULTIPLIER_SIGNED_EN is defined.
module shift_add_multiplier_datapath
  import shift_add_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_load,
  input  logic                      i_step,
  input  logic [DATA_WIDTH-1:0]     i_multiplicand,
  input  logic [DATA_WIDTH-1:0]     i_multiplier,
  output logic                      o_last_step,
  output logic [2*DATA_WIDTH-1:0]   o_product
);

  localparam int CNT_WIDTH = calc_cnt_width(DATA_WIDTH);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic [PROD_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [PROD_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PROD_WIDTH-1:0] product_q, product_d;

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [PROD_WIDTH-1:0] addend;
  logic [PROD_WIDTH-1:0] sum;

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic sign_q, sign_d;
`endif

  assign o_last_step = (cnt_q == CNT_WIDTH'(1));
  assign o_product   = product_q;

  always_comb begin
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    // -2^(W-1) negates to itself, which read unsigned is the exact magnitude.
    op_a = i_multiplicand[DATA_WIDTH-1] ? -i_multiplicand : i_multiplicand;
    op_b = i_multiplier[DATA_WIDTH-1]   ? -i_multiplier   : i_multiplier;
`else
    op_a = i_multiplicand;
    op_b = i_multiplier;
`endif
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = acc_q + addend;
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    sign_d    = sign_q;
`endif
    if (i_load) begin
      mcand_d  = {{DATA_WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = CNT_WIDTH'(DATA_WIDTH);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      sign_d   = i_multiplicand[DATA_WIDTH-1] ^ i_multiplier[DATA_WIDTH-1];
`endif
    end else if (i_step) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_WIDTH'(1);
      // The last partial product is folded in on the same edge the result is published.
      if (o_last_step) begin
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
        product_d = sign_q ? -sum : sum;
`else
        product_d = sum;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with valid/ready on both sides, one bit per clock.
// Define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's-complement operands and product.
//
// state | meaning
// IDLE  | waiting for an operand pair, o_ready high
// RUN   | retiring one multiplier bit per clock, DATA_WIDTH clocks
// DONE  | o_product valid, holding until downstream takes it
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_multiplicand,
  input  logic [DATA_WIDTH-1:0]   i_multiplier,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_product,
  output logic                    o_busy
);

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   valid_q, valid_d;
  logic   busy_q, busy_d;
  logic   load;
  logic   step;
  logic   last_step;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with the state flop.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

  shift_add_multiplier_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_load         (load),
    .i_step         (step),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_last_step    (last_step),
    .o_product      (o_product)
  );

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential shift-and-add multiplier; the inverse-direction companion to the long-division divider in the DSP filter library.
- Produces a 2*DATA_WIDTH product from two DATA_WIDTH operands, retiring one multiplier bit per clock.
- Sits in the same filter datapaths as the divider, for gain and scale stages.
- Uses a valid/ready handshake on both input and output, so it chains directly with the divider.

Parameters:
- DATA_WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), width of the iteration counter (derived; not overridden).

Ports:
- i_clk  input  1  single system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands (high only in IDLE).
- i_multiplicand  input  DATA_WIDTH  operand A.
- i_multiplier  input  DATA_WIDTH  operand B.
- o_valid  output  1  o_product valid.
- i_ready  input  1  downstream accepts the product.
- o_product  output  2*DATA_WIDTH  A*B.
- o_busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (i_reset_n low, asynchronous): state IDLE; o_product=0; o_valid=0; o_busy=0; counter=0; internal accumulator and shift registers=0. o_ready=1 once reset is released.
- Reset mid-operation: the in-flight operation is discarded; no o_valid pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready at a rising edge (accept edge E0): latch A and B, clear the accumulator, set counter=DATA_WIDTH, go to RUN.
- RUN:
  - o_ready=0.
  - Each edge: if B[0]==1, add A<<k (k = iteration index) into the 2W-bit accumulator.
  - Then B>>=1 and counter-=1.
  - When counter reaches 0 (edge E0+DATA_WIDTH): write the accumulator to o_product, set o_valid=1, go to DONE.
  - Latency is fixed at DATA_WIDTH cycles from the accept edge. There is no early termination, including for zero operands.
- DONE:
  - o_valid=1 and o_product held stable until i_valid... no: until i_ready is sampled high.
  - On o_valid&&i_ready: o_valid=0, go to IDLE. A new operand is accepted no earlier than the edge after that.
- i_valid while not in IDLE is ignored; operands change only at the accept edge.
- Width rules: the accumulator is 2*DATA_WIDTH bits. Unsigned overflow is impossible; maximum result is (2^W-1)^2.
- Throughput: one product per DATA_WIDTH+2 cycles with an always-ready sink.
- i_ready asserted before o_valid has no effect.

Optional Feature:
- Macro: SHIFT_ADD_MULTIPLIER_SIGNED_EN.
- Defined:
  - Operands and product are two's complement.
  - At the accept edge, the magnitudes |A| and |B| are latched along with the result sign (A[W-1]^B[W-1]).
  - At the final RUN edge, the product is negated if the sign is set.
  - Latency is unchanged. The most negative operand (-2^(W-1)) is handled exactly: its magnitude fits in W bits unsigned.
- Undefined: operands and product are unsigned; no sign logic is synthesized.

Decomposition:
- Package shift_add_multiplier_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam DEFAULT_DATA_WIDTH=8;
  - a function computing CNT_WIDTH.
- One sub-module is natural: shift_add_multiplier_datapath. It contains the accumulator, shift registers, counter, and optional sign correction, driven by load/step strobes from the top-level FSM.

Test Plan:
- Unsigned basic: A=8'd13, B=8'd11, i_ready=1 -> o_valid rises exactly 8 cycles after the accept edge with o_product=16'h008F; o_ready returns high the cycle after the handshake.
- Extremes: A=8'hFF, B=8'hFF -> 16'hFE01. A=8'h00, B=8'hA5 -> 16'h0000, still after 8 cycles.
- Back-pressure: A=8'd200, B=8'd3 with i_ready=0 for 5 cycles after o_valid -> o_product=16'h0258 held stable; o_valid deasserts on the edge where i_ready=1; i_valid pulses during RUN/DONE are ignored.
- Reset mid-operation: assert i_reset_n=0 asynchronously 3 cycles into RUN -> outputs 0 immediately; after release, no o_valid appears; the next A=2, B=3 yields 16'h0006.
- Signed (macro defined):
  - A=8'hFD(-3), B=8'd5 -> 16'hFFF1.
  - A=8'h80, B=8'h80 -> 16'h4000.
  - A=8'h80, B=8'h01 -> 16'hFF80.
- Back-to-back: two transfers (7*9, then 15*15) with i_valid held high -> 16'h003F then 16'h00E1, accept edges spaced DATA_WIDTH+2 cycles apart.
